// File: rtl/timed_latch_pkg.sv
// Shared definitions for the timed trigger-hold latch bank.
package timed_latch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam int unsigned DefaultW = 32;

endpackage

// File: rtl/timed_latch_chan.sv
// One latch channel: trigger qualification, IDLE/HOLD/LOCKOUT FSM and its down-counter.
module timed_latch_chan
    import timed_latch_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] hold_i,
    input  logic [W-1:0] lockout_i,
    input  logic         retrig_i,
    input  logic         edge_i,
    input  logic         en_i,
    input  logic         trig_i,
    output logic         out,
    output logic         done_o
);

    state_e       state;
    logic [W-1:0] cnt;
    logic         trig_prev;
    logic         ev;
    logic         hold_nz;

    assign ev      = en_i & (edge_i ? (trig_i & ~trig_prev) : trig_i);
    assign hold_nz = (hold_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out       <= 1'b0;
            done_o    <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_prev <= trig_i;
            done_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev && hold_nz) begin
                        state <= ST_HOLD;
                        cnt   <= hold_i - 1'b1;
                        out   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Retrigger wins over expiry on the same edge.
                    if (retrig_i && ev && hold_nz) begin
                        cnt <= hold_i - 1'b1;
                    end else if (cnt == '0) begin
                        out    <= 1'b0;
                        done_o <= 1'b1;
                        if (lockout_i != '0) begin
                            state <= ST_LOCKOUT;
                            cnt   <= lockout_i - 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/timed_latch_multi.sv
// Bank of NCH independent trigger-hold latches sharing mode and period settings.
module timed_latch_multi
    import timed_latch_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = DefaultW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   hold_i,
    input  logic [W-1:0]   lockout_i,
    input  logic           retrig_i,
    input  logic           edge_i,
    input  logic [NCH-1:0] en_i,
    input  logic [NCH-1:0] trig_i,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] done_o
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        timed_latch_chan #(
            .W(W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .hold_i   (hold_i),
            .lockout_i(lockout_i),
            .retrig_i (retrig_i),
            .edge_i   (edge_i),
            .en_i     (en_i[g]),
            .trig_i   (trig_i[g]),
            .out      (out[g]),
            .done_o   (done_o[g])
        );
    end

endmodule

// File: tb/tb_timed_latch_multi.sv
// Directed bench for timed_latch_multi: vector table plus multi-cycle corner sequences.
module tb_timed_latch_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   hold;
    logic [W-1:0]   lockout;
    logic           retrig;
    logic           edg;
    logic [NCH-1:0] en;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] out;
    logic [NCH-1:0] done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] trig;
        logic [W-1:0]   hold;
        logic [NCH-1:0] exp_out;
        logic [NCH-1:0] exp_done;
    } vec_t;

    vec_t vecs[17];

    timed_latch_multi #(
        .NCH(NCH),
        .W  (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (hold),
        .lockout_i(lockout),
        .retrig_i (retrig),
        .edge_i   (edg),
        .en_i     (en),
        .trig_i   (trig),
        .out      (out),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] e, input logic [3:0] t, input logic [15:0] h,
                                input logic [3:0] o, input logic [3:0] d);
        vec_t v;
        v.en = e; v.trig = t; v.hold = h; v.exp_out = o; v.exp_done = d;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        trig  = '0;
        step();
        reset = 1'b0;
    endtask

    int hi_cnt;
    int dn_cnt;

    initial begin
        // Basic hold, enable masking, hold=0 and hold=1, all level mode without lockout.
        vecs[0]  = mk(4'hF, 4'h1, 16'd5, 4'h1, 4'h0);
        vecs[1]  = mk(4'hF, 4'h0, 16'd5, 4'h1, 4'h0);
        vecs[2]  = mk(4'hF, 4'h0, 16'd5, 4'h1, 4'h0);
        vecs[3]  = mk(4'hF, 4'h0, 16'd5, 4'h1, 4'h0);
        vecs[4]  = mk(4'hF, 4'h0, 16'd5, 4'h1, 4'h0);
        vecs[5]  = mk(4'hF, 4'h0, 16'd5, 4'h0, 4'h1);
        vecs[6]  = mk(4'hF, 4'h0, 16'd5, 4'h0, 4'h0);
        vecs[7]  = mk(4'hA, 4'hF, 16'd3, 4'hA, 4'h0);
        vecs[8]  = mk(4'h8, 4'h0, 16'd3, 4'hA, 4'h0);
        vecs[9]  = mk(4'h8, 4'h2, 16'd3, 4'hA, 4'h0);
        vecs[10] = mk(4'h8, 4'h0, 16'd3, 4'h0, 4'hA);
        vecs[11] = mk(4'hF, 4'h0, 16'd3, 4'h0, 4'h0);
        vecs[12] = mk(4'hF, 4'h1, 16'd0, 4'h0, 4'h0);
        vecs[13] = mk(4'hF, 4'h0, 16'd0, 4'h0, 4'h0);
        vecs[14] = mk(4'hF, 4'h1, 16'd1, 4'h1, 4'h0);
        vecs[15] = mk(4'hF, 4'h0, 16'd1, 4'h0, 4'h1);
        vecs[16] = mk(4'hF, 4'h0, 16'd1, 4'h0, 4'h0);

        reset = 1'b1; hold = '0; lockout = '0; retrig = 1'b0; edg = 1'b0; en = '0; trig = '0;
        step();
        step();
        check("reset out", 32'(out), 32'h0);
        check("reset done", 32'(done), 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            en = vecs[i].en; trig = vecs[i].trig; hold = vecs[i].hold;
            step();
            check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
        end

        // Retrigger on/off with hold=10 and triggers at edges 0 and 7.
        en = 4'hF; hold = 16'd10; lockout = '0; edg = 1'b0;
        for (int r = 1; r >= 0; r--) begin
            retrig = r[0];
            do_reset();
            hi_cnt = 0; dn_cnt = 0;
            for (int i = 0; i < 30; i++) begin
                trig = (i == 0 || i == 7) ? 4'h1 : 4'h0;
                step();
                if (out[0]) hi_cnt++;
                if (done[0]) dn_cnt++;
            end
            check($sformatf("retrig%0d high", r), 32'(hi_cnt), (r == 1) ? 32'd17 : 32'd10);
            check($sformatf("retrig%0d done", r), 32'(dn_cnt), 32'd1);
        end

        // Retrigger landing on the expiry edge extends instead of expiring.
        retrig = 1'b1; hold = 16'd3;
        do_reset();
        hi_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            trig = (i == 0 || i == 3) ? 4'h1 : 4'h0;
            step();
            if (out[0]) hi_cnt++;
            if (done[0]) dn_cnt++;
        end
        check("retrig at expiry high", 32'(hi_cnt), 32'd6);
        check("retrig at expiry done", 32'(dn_cnt), 32'd1);

        // Lockout with level trigger held: 3 high, 5 low, repeating.
        retrig = 1'b0; hold = 16'd3; lockout = 16'd4; edg = 1'b0;
        do_reset();
        trig = 4'h1;
        for (int i = 0; i < 24; i++) begin
            step();
            check($sformatf("lockout level c%0d", i), 32'(out[0]), ((i % 8) < 3) ? 32'd1 : 32'd0);
        end

        // Same held trigger in edge mode gives one pulse only.
        edg = 1'b1;
        do_reset();
        trig = 4'h1;
        hi_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (out[0]) hi_cnt++;
            if (done[0]) dn_cnt++;
        end
        check("lockout edge high", 32'(hi_cnt), 32'd3);
        check("lockout edge done", 32'(dn_cnt), 32'd1);

        // Reset during HOLD with cnt=40, then trigger held through reset release in edge mode.
        edg = 1'b0; lockout = '0; hold = 16'd50;
        do_reset();
        trig = 4'h1;
        step();
        trig = 4'h0;
        for (int i = 0; i < 9; i++) step();
        check("pre-reset out", 32'(out[0]), 32'd1);
        reset = 1'b1;
        step();
        check("mid reset out", 32'(out), 32'h0);
        check("mid reset done", 32'(done), 32'h0);
        edg = 1'b1; trig = 4'h4;
        step();
        reset = 1'b0;
        step();
        check("post reset edge start", 32'(out), 32'h4);
        hi_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (out[0]) hi_cnt++;
            if (done[0]) dn_cnt++;
        end
        check("post reset ch0 idle", 32'(hi_cnt + dn_cnt), 32'd0);

        // Maximum hold for W=16.
        edg = 1'b0; hold = 16'hFFFF;
        do_reset();
        hi_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 65600; i++) begin
            trig = (i == 0) ? 4'h1 : 4'h0;
            step();
            if (out[0]) hi_cnt++;
            if (done[0]) begin
                dn_cnt++;
                check("max hold done timing", 32'(i), 32'd65535);
            end
        end
        check("max hold high", 32'(hi_cnt), 32'd65535);
        check("max hold done count", 32'(dn_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
